// File: rtl/voice_allocator.sv
// Voice allocator: note events to 8 voices with linear ASR envelopes.
// Frequencies Q12.20 Hz, volumes Q.20, both registered.
module voice_allocator #(
  parameter int TICK_DIV     = 1024,
  parameter int ATTACK_STEP  = 1 << 14,
  parameter int RELEASE_STEP = 1 << 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_note_valid,
  output logic             o_note_ready,
  input  logic             i_note_on,
  input  logic [6:0]       i_note_num,
  input  logic [6:0]       i_velocity,
  output logic [7:0][31:0] o_frequencies,
  output logic [7:0][31:0] o_voice_volumes
);

  localparam int          TW     = $clog2(TICK_DIV);
  localparam logic [31:0] F55    = 32'd57671680;
  localparam logic [31:0] A_STEP = 32'(ATTACK_STEP);
  localparam logic [31:0] R_STEP = 32'(RELEASE_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_APPLY} fsm_t;
  typedef enum logic [1:0] {V_FREE, V_ATTACK, V_SUSTAIN, V_RELEASE} vst_t;

  fsm_t          r_fsm;
  logic          r_ready;
  logic          r_on;
  logic [6:0]    r_note;
  logic [6:0]    r_vel;
  logic [2:0]    r_idx;
  logic          r_free_ok;
  logic [2:0]    r_free_idx;
  logic          r_match_ok;
  logic [2:0]    r_match_idx;
  logic [2:0]    r_steal;
  logic [TW-1:0] r_tick;

  vst_t          r_vst    [8];
  logic [6:0]    r_vnote  [8];
  logic [31:0]   r_level  [8];
  logic [31:0]   r_target [8];
  logic [31:0]   r_freq   [8];

  logic          w_tick;
  logic [7:0]    w_sum;
  logic [3:0]    w_oct;
  logic [3:0]    w_k;
  logic [31:0]   w_base;
  logic [31:0]   w_freq;
  logic          w_note_ok;
  logic [7:0]    w_vp1;
  logic [31:0]   w_tgt;
  logic [2:0]    w_on_idx;
  logic [7:0]    w_hit;

  // One octave of equal temperament, A4 (note 69) upward.
  function automatic logic [31:0] rom(input logic [3:0] k);
    case (k)
      4'd0:    rom = 32'd461373440;
      4'd1:    rom = 32'd488808133;
      4'd2:    rom = 32'd517874176;
      4'd3:    rom = 32'd548668578;
      4'd4:    rom = 32'd581294109;
      4'd5:    rom = 32'd615859656;
      4'd6:    rom = 32'd652480576;
      4'd7:    rom = 32'd691279090;
      4'd8:    rom = 32'd732384684;
      4'd9:    rom = 32'd775934543;
      4'd10:   rom = 32'd822074013;
      default: rom = 32'd870957077;
    endcase
  endfunction

  assign o_note_ready = r_ready;
  assign w_tick       = (r_tick == TW'(TICK_DIV - 1));

  // Note 69 maps to octave 6 / index 0 after the +3 bias.
  assign w_sum     = {1'b0, r_note} + 8'd3;
  assign w_oct     = 4'(w_sum / 8'd12);
  assign w_k       = 4'(w_sum % 8'd12);
  assign w_base    = rom(w_k);
  assign w_freq    = (w_oct >= 4'd6) ? (w_base << (w_oct - 4'd6))
                                     : (w_base >> (4'd6 - w_oct));
  assign w_note_ok = (r_note <= 7'd95);
  assign w_vp1     = {1'b0, r_vel} + 8'd1;
  assign w_tgt     = {11'd0, w_vp1, 13'd0};

  // Pick the voice each APPLY touches.
  always_comb begin
    w_on_idx = r_steal;
    if (r_match_ok)
      w_on_idx = r_match_idx;
    else if (r_free_ok)
      w_on_idx = r_free_idx;
    for (int i = 0; i < 8; i++) begin
      w_hit[i] = 1'b0;
      if (r_fsm == S_APPLY && w_note_ok) begin
        if (r_on)
          w_hit[i] = (3'(i) == w_on_idx);
        else
          w_hit[i] = (r_vnote[i] == r_note) &&
                     (r_vst[i] == V_ATTACK || r_vst[i] == V_SUSTAIN);
      end
    end
  end

  // Envelope tick divider.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_tick <= '0;
    else
      r_tick <= w_tick ? '0 : r_tick + 1'b1;
  end

  // Event handshake, voice scan and steal pointer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fsm       <= S_IDLE;
      r_ready     <= 1'b0;
      r_on        <= 1'b0;
      r_note      <= '0;
      r_vel       <= '0;
      r_idx       <= '0;
      r_free_ok   <= 1'b0;
      r_free_idx  <= '0;
      r_match_ok  <= 1'b0;
      r_match_idx <= '0;
      r_steal     <= '0;
    end else begin
      unique case (r_fsm)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (i_note_valid && r_ready) begin
            r_ready    <= 1'b0;
            r_on       <= i_note_on;
            r_note     <= i_note_num;
            r_vel      <= i_velocity;
            r_idx      <= '0;
            r_free_ok  <= 1'b0;
            r_match_ok <= 1'b0;
            r_fsm      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!r_free_ok && r_vst[r_idx] == V_FREE) begin
            r_free_ok  <= 1'b1;
            r_free_idx <= r_idx;
          end
          if (!r_match_ok && r_vst[r_idx] != V_FREE &&
              r_vnote[r_idx] == r_note) begin
            r_match_ok  <= 1'b1;
            r_match_idx <= r_idx;
          end
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7)
            r_fsm <= S_APPLY;
        end
        S_APPLY: begin
          r_ready <= 1'b1;
          r_fsm   <= S_IDLE;
          if (r_on && w_note_ok && !r_match_ok && !r_free_ok)
            r_steal <= r_steal + 3'd1;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  // Per-voice state: event application overrides the envelope tick.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 8; i++) begin
        r_vst[i]    <= V_FREE;
        r_vnote[i]  <= '0;
        r_level[i]  <= '0;
        r_target[i] <= '0;
        r_freq[i]   <= F55;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_hit[i]) begin
          if (r_on) begin
            r_vst[i]    <= V_ATTACK;
            r_target[i] <= w_tgt;
            if (!r_match_ok) begin
              r_level[i] <= '0;
              r_freq[i]  <= w_freq;
              r_vnote[i] <= r_note;
            end
          end else begin
            r_vst[i] <= V_RELEASE;
          end
        end else if (w_tick) begin
          unique case (r_vst[i])
            V_ATTACK: begin
              if (r_level[i] + A_STEP >= r_target[i]) begin
                r_level[i] <= r_target[i];
                r_vst[i]   <= V_SUSTAIN;
              end else begin
                r_level[i] <= r_level[i] + A_STEP;
              end
            end
            V_RELEASE: begin
              if (r_level[i] <= R_STEP) begin
                r_level[i] <= '0;
                r_vst[i]   <= V_FREE;
              end else begin
                r_level[i] <= r_level[i] - R_STEP;
              end
            end
            V_FREE:    r_level[i] <= '0;
            default:   r_level[i] <= r_level[i];
          endcase
        end
      end
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 8; i++) begin
        o_frequencies[i]   <= F55;
        o_voice_volumes[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        o_frequencies[i]   <= r_freq[i];
        o_voice_volumes[i] <= r_level[i];
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: reset, latency, allocation, steal,
// envelope timing and reset during scan.
module tb_voice_allocator;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic             ready;
  logic             on;
  logic [6:0]       note;
  logic [6:0]       vel;
  logic [7:0][31:0] freqs;
  logic [7:0][31:0] vols;

  localparam logic [31:0] F55  = 32'd57671680;
  localparam logic [31:0] A4   = 32'd461373440;
  localparam logic [31:0] FULL = 32'h0010_0000;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        on;
    logic [6:0]  note;
    logic [6:0]  vel;
    int          voice;
    logic [31:0] freq;
    bit          chkf;
  } vec_t;

  typedef struct {
    int          voice;
    logic [31:0] freq;
    bit          chkf;
    bit          chkv;
    logic [31:0] pre;
    bit          chkpre;
    string       name;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  voice_allocator #(.TICK_DIV(16)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_note_valid    (valid),
    .o_note_ready    (ready),
    .i_note_on       (on),
    .i_note_num      (note),
    .i_velocity      (vel),
    .o_frequencies   (freqs),
    .o_voice_volumes (vols)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act,
                           input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  task automatic wait_ready(input string name, output bit ok);
    int n = 0;
    while (!ready && n < 100) begin
      step(1);
      n++;
    end
    ok = ready;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_ready: got 0 expected 1", name);
    end
  endtask

  // Drive one event; compare the pushed expectation 10 edges later.
  task automatic send(input logic o, input logic [6:0] nn,
                      input logic [6:0] vv, input int voice,
                      input logic [31:0] f, input bit cf, input bit cv,
                      input logic [31:0] pre, input bit cpre,
                      input string name);
    exp_t e;
    bit   ok;
    wait_ready(name, ok);
    if (!ok) return;
    e = '{voice, f, cf, cv, pre, cpre, name};
    sbq.push_back(e);
    valid = 1'b1;
    on    = o;
    note  = nn;
    vel   = vv;
    step(1);
    valid = 1'b0;
    step(9);
    e = sbq.pop_front();
    if (e.chkpre)
      chk({e.name, "_pre"}, freqs[e.voice], e.pre);
    step(1);
    if (e.chkf)
      chk({e.name, "_freq"}, freqs[e.voice], e.freq);
    if (e.chkv)
      chk({e.name, "_vol"}, vols[e.voice], 32'd0);
  endtask

  initial begin
    int n;
    bit ok;
    rst   = 1'b1;
    valid = 1'b0;
    on    = 1'b0;
    note  = '0;
    vel   = '0;

    vecs[0] = '{1'b1, 7'd9,  7'd100, 0, A4 >> 5, 1'b1};
    vecs[1] = '{1'b1, 7'd21, 7'd100, 1, A4 >> 4, 1'b1};
    vecs[2] = '{1'b1, 7'd33, 7'd100, 2, A4 >> 3, 1'b1};
    vecs[3] = '{1'b1, 7'd45, 7'd100, 3, A4 >> 2, 1'b1};
    vecs[4] = '{1'b1, 7'd57, 7'd100, 4, A4 >> 1, 1'b1};
    vecs[5] = '{1'b1, 7'd81, 7'd100, 5, A4 << 1, 1'b1};
    vecs[6] = '{1'b1, 7'd93, 7'd100, 6, A4 << 2, 1'b1};
    vecs[7] = '{1'b1, 7'd70, 7'd100, 7, 32'd0,   1'b0};
    vecs[8] = '{1'b1, 7'd69, 7'd100, 0, A4,      1'b1};
    vecs[9] = '{1'b1, 7'd9,  7'd100, 1, A4 >> 5, 1'b1};

    // Reset state
    step(3);
    chk("rst_ready_low", {31'd0, ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst_vol%0d", i), vols[i], 32'd0);
      chk($sformatf("rst_freq%0d", i), freqs[i], F55);
    end
    rst = 1'b0;
    chk("ready_low_at_release", {31'd0, ready}, 32'd0);
    step(1);
    chk("ready_after_release", {31'd0, ready}, 32'd1);

    // A4 full velocity: exact latency and attack time
    send(1'b1, 7'd69, 7'd127, 0, A4, 1'b1, 1'b1, F55, 1'b1, "s2_a4");
    n = 0;
    while (vols[0] !== FULL && n < 1100) begin
      step(1);
      n++;
    end
    chk("s2_attack_peak", vols[0], FULL);
    chk_range("s2_attack_cycles", n, 1005, 1045);
    step(100);
    chk("s2_hold", vols[0], FULL);

    // Note-off: release slope and time, then reuse of voice 0
    send(1'b0, 7'd69, 7'd0, 0, A4, 1'b1, 1'b0, 32'd0, 1'b0, "s5_off");
    n = 0;
    while (vols[0] === FULL && n < 40) begin
      step(1);
      n++;
    end
    chk("s5_first_step", vols[0], FULL - 32'd4096);
    while (vols[0] !== 32'd0 && n < 4200) begin
      step(1);
      n++;
    end
    chk("s5_released", vols[0], 32'd0);
    chk_range("s5_release_cycles", n, 4080, 4115);
    send(1'b1, 7'd57, 7'd127, 0, A4 >> 1, 1'b1, 1'b1, 32'd0, 1'b0,
         "s5_realloc");

    // Reset during scan drops the event
    step(40);
    chk("s6_vol_nonzero", {31'd0, vols[0] != 32'd0}, 32'd1);
    wait_ready("s6", ok);
    valid = 1'b1;
    on    = 1'b1;
    note  = 7'd45;
    vel   = 7'd127;
    step(1);
    valid = 1'b0;
    step(3);
    rst = 1'b1;
    #1;
    chk("s6_vol0_cleared", vols[0], 32'd0);
    chk("s6_freq0_cleared", freqs[0], F55);
    chk("s6_ready_low", {31'd0, ready}, 32'd0);
    step(2);
    rst = 1'b0;
    step(1);
    chk("s6_ready_after", {31'd0, ready}, 32'd1);
    step(12);
    chk("s6_event_lost_freq", freqs[0], F55);
    chk("s6_event_lost_vol", vols[1], 32'd0);

    // Low note, out-of-range note, then next free voice
    do_reset();
    send(1'b1, 7'd33, 7'd64, 0, F55, 1'b1, 1'b1, 32'd0, 1'b0, "s3_n33");
    send(1'b1, 7'd96, 7'd64, 1, F55, 1'b1, 1'b1, 32'd0, 1'b0, "s3_n96");
    step(40);
    chk("s3_n96_no_voice", vols[1], 32'd0);
    send(1'b1, 7'd57, 7'd64, 1, A4 >> 1, 1'b1, 1'b1, 32'd0, 1'b0,
         "s3_next");

    // Fill all voices, then round-robin steal
    do_reset();
    for (int i = 0; i < 10; i++)
      send(vecs[i].on, vecs[i].note, vecs[i].vel, vecs[i].voice,
           vecs[i].freq, vecs[i].chkf, 1'b1, 32'd0, 1'b0,
           $sformatf("s4_v%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
